// File: rtl/axi_apb_bridge_mc.sv
// rtl/axi_apb_bridge_mc.sv - AXI-Lite to multi-slave APB bridge, one transaction at a time.
// Optional ACCESS timeout is compiled in with `define APB_TIMEOUT_EN.
module axi_apb_bridge_mc #(
   parameter int DATA_W      = 32,
   parameter int NUM_SLAVES  = 4,
   parameter int WIN_BITS    = 12,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                           aclk,
   input  logic                           areset_n,
   input  logic [31:0]                    awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_W-1:0]              wdata,
   input  logic [DATA_W/8-1:0]            wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [31:0]                    araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_W-1:0]              rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [WIN_BITS-1:0]            paddr,
   output logic [NUM_SLAVES-1:0]          psel,
   output logic                           penable,
   output logic                           pwrite,
   output logic [DATA_W-1:0]              pwdata,
   output logic [DATA_W/8-1:0]            pstrb,
   input  logic [NUM_SLAVES*DATA_W-1:0]   prdata,
   input  logic [NUM_SLAVES-1:0]          pready,
   input  logic [NUM_SLAVES-1:0]          pslverr
);
   localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int IDX_W1 = IDX_W + 1;
   localparam logic [IDX_W:0] SLV_CNT = IDX_W1'(NUM_SLAVES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   // Returns {miss, index}; any address bit above the index field forces a miss.
   function automatic logic [IDX_W:0] decode(input logic [31:0] addr);
      logic [IDX_W-1:0] idx;
      logic             miss;
      idx  = addr[WIN_BITS +: IDX_W];
      miss = ((addr >> (WIN_BITS + IDX_W)) != 32'd0) || ({1'b0, idx} >= SLV_CNT);
      return {miss, idx};
   endfunction

   state_t           state;
   logic             grant_rd;
   logic [IDX_W-1:0] idx_q;
   logic             miss_q;
   logic [IDX_W:0]   aw_dec;
   logic [IDX_W:0]   ar_dec;
   logic             wr_pend;
   logic             rd_pend;

   assign aw_dec  = decode(awaddr);
   assign ar_dec  = decode(araddr);
   assign wr_pend = awvalid && wvalid;
   assign rd_pend = arvalid;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt;
`endif

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state    <= IDLE;
         grant_rd <= 1'b0;
         idx_q    <= '0;
         miss_q   <= 1'b0;
         awready  <= 1'b0;
         wready   <= 1'b0;
         arready  <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= 2'b00;
         rvalid   <= 1'b0;
         rresp    <= 2'b00;
         rdata    <= '0;
         paddr    <= '0;
         psel     <= '0;
         penable  <= 1'b0;
         pwrite   <= 1'b0;
         pwdata   <= '0;
         pstrb    <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A ready pulse marks the handshake cycle; the request was latched when it was raised.
               if (awready || arready) begin
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  arready <= 1'b0;
                  if (miss_q) begin
                     state <= RESP;
                     if (pwrite) begin
                        bvalid <= 1'b1;
                        bresp  <= 2'b11;
                     end else begin
                        rvalid <= 1'b1;
                        rresp  <= 2'b11;
                        rdata  <= '0;
                     end
                  end else begin
                     psel  <= NUM_SLAVES'(1) << idx_q;
                     state <= SETUP;
                  end
               end else if (wr_pend && (!rd_pend || !grant_rd)) begin
                  awready  <= 1'b1;
                  wready   <= 1'b1;
                  grant_rd <= 1'b1;
                  pwrite   <= 1'b1;
                  paddr    <= awaddr[WIN_BITS-1:0];
                  pwdata   <= wdata;
                  pstrb    <= wstrb;
                  idx_q    <= aw_dec[IDX_W-1:0];
                  miss_q   <= aw_dec[IDX_W];
               end else if (rd_pend) begin
                  arready  <= 1'b1;
                  grant_rd <= 1'b0;
                  pwrite   <= 1'b0;
                  paddr    <= araddr[WIN_BITS-1:0];
                  pwdata   <= '0;
                  pstrb    <= '0;
                  idx_q    <= ar_dec[IDX_W-1:0];
                  miss_q   <= ar_dec[IDX_W];
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (pready[idx_q]) begin
                  psel    <= '0;
                  penable <= 1'b0;
                  state   <= RESP;
                  if (pwrite) begin
                     bvalid <= 1'b1;
                     bresp  <= {pslverr[idx_q], 1'b0};
                  end else begin
                     rvalid <= 1'b1;
                     rresp  <= {pslverr[idx_q], 1'b0};
                     rdata  <= prdata[idx_q * DATA_W +: DATA_W];
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  psel    <= '0;
                  penable <= 1'b0;
                  state   <= RESP;
                  if (pwrite) begin
                     bvalid <= 1'b1;
                     bresp  <= 2'b10;
                  end else begin
                     rvalid <= 1'b1;
                     rresp  <= 2'b10;
                     rdata  <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if ((bvalid && bready) || (rvalid && rready)) begin
                  bvalid <= 1'b0;
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_apb_bridge_mc.sv
// tb/tb_axi_apb_bridge_mc.sv - directed self-checking bench for axi_apb_bridge_mc.
// Runs the timeout scenario when APB_TIMEOUT_EN is defined, the no-timeout scenario otherwise.
module tb_axi_apb_bridge_mc;
   logic         aclk;
   logic         areset_n;
   logic [31:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [11:0]  paddr;
   logic [3:0]   psel;
   logic         penable;
   logic         pwrite;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic [127:0] prdata;
   logic [3:0]   pready;
   logic [3:0]   pslverr;

   int           tests;
   int           fails;
   int           cyc;
   int           acc_cnt;
   int           wait_cfg [4];
   logic [31:0]  rdata_cfg [4];
   logic [3:0]   err_cfg;
   logic         psel_seen;

   axi_apb_bridge_mc #(
      .DATA_W(32), .NUM_SLAVES(4), .WIN_BITS(12), .TIMEOUT_CYC(4)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
      .pready(pready), .pslverr(pslverr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // APB slave model: each slave answers after wait_cfg[i] ACCESS cycles.
   initial acc_cnt = 0;
   always @(posedge aclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

   always_comb begin
      pready  = '0;
      pslverr = '0;
      prdata  = '0;
      for (int i = 0; i < 4; i++) begin
         pready[i]            = psel[i] && penable && (acc_cnt >= wait_cfg[i]);
         pslverr[i]           = psel[i] && err_cfg[i];
         prdata[i*32 +: 32]   = rdata_cfg[i];
      end
   end

   always @(negedge aclk) if (|psel) psel_seen = 1'b1;

   // which: 0 awready, 1 arready, 2 bvalid, 3 rvalid, 4 awready|arready, 5 bvalid|rvalid
   task automatic wait_sig(input int which, output int c);
      logic h;
      c = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge aclk);
         case (which)
            0: h = awready;
            1: h = arready;
            2: h = bvalid;
            3: h = rvalid;
            4: h = awready | arready;
            default: h = bvalid | rvalid;
         endcase
         if (h) begin
            c = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      areset_n = 1'b0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      awaddr = 32'h1000; araddr = 32'h2000;
      repeat (3) @(negedge aclk);
      tests++;
      if ({awready, wready, arready} !== 3'b000) begin
         fails++; $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready});
      end
      tests++;
      if ({bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
         fails++; $display("FAIL reset_resp: got %h expected 0", {bvalid, rvalid, bresp, rresp, rdata});
      end
      tests++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
         fails++; $display("FAIL reset_apb: got %h expected 0", {psel, penable, pwrite, paddr, pwdata, pstrb});
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      areset_n = 1'b1;
      repeat (2) @(negedge aclk);
   endtask

   task automatic test_write();
      int n, c;
      wait_cfg[1] = 0;
      awaddr = 32'h0000_1004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      wait_sig(0, n);
      tests++;
      if (n < 0 || wready !== 1'b1) begin
         fails++; $display("FAIL wr_accept: got cycle %0d wready %b expected wready 1", n, wready);
      end
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      tests++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {4'b0010, 1'b0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF}) begin
         fails++; $display("FAIL wr_setup: got psel %b en %b paddr %h pwdata %h pstrb %h expected 0010 0 004 deadbeef f",
                           psel, penable, paddr, pwdata, pstrb);
      end
      @(negedge aclk);
      tests++;
      if ({psel, penable, paddr} !== {4'b0010, 1'b1, 12'h004}) begin
         fails++; $display("FAIL wr_access: got psel %b en %b paddr %h expected 0010 1 004", psel, penable, paddr);
      end
      wait_sig(2, c);
      tests++;
      if (c !== n + 3 || bresp !== 2'b00 || psel !== 4'b0000 || penable !== 1'b0) begin
         fails++; $display("FAIL wr_resp: got cycle %0d bresp %b psel %b expected cycle %0d bresp 00 psel 0000", c, bresp, psel, n + 3);
      end
      @(negedge aclk);
      tests++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         fails++; $display("FAIL wr_hold: got bvalid %b bresp %b expected 1 00", bvalid, bresp);
      end
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      tests++;
      if (bvalid !== 1'b0) begin
         fails++; $display("FAIL wr_done: got bvalid %b expected 0", bvalid);
      end
   endtask

   task automatic test_read_wait();
      int n, c;
      wait_cfg[3] = 2; rdata_cfg[3] = 32'h1234_5678;
      araddr = 32'h0000_3008; arvalid = 1'b1; rready = 1'b0;
      wait_sig(1, n);
      @(negedge aclk);
      arvalid = 1'b0;
      tests++;
      if ({psel, penable, pwrite, paddr, pstrb} !== {4'b1000, 1'b0, 1'b0, 12'h008, 4'h0}) begin
         fails++; $display("FAIL rd_setup: got psel %b en %b pwrite %b paddr %h pstrb %h expected 1000 0 0 008 0",
                           psel, penable, pwrite, paddr, pstrb);
      end
      repeat (3) @(negedge aclk);
      tests++;
      if ({psel, penable, paddr, pstrb} !== {4'b1000, 1'b1, 12'h008, 4'h0}) begin
         fails++; $display("FAIL rd_wait_stable: got psel %b en %b paddr %h pstrb %h expected 1000 1 008 0", psel, penable, paddr, pstrb);
      end
      wait_sig(3, c);
      tests++;
      if (c !== n + 5 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin
         fails++; $display("FAIL rd_resp: got cycle %0d rdata %h rresp %b expected cycle %0d rdata 12345678 rresp 00",
                           c, rdata, rresp, n + 5);
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      tests++;
      if (rvalid !== 1'b0) begin
         fails++; $display("FAIL rd_done: got rvalid %b expected 0", rvalid);
      end
   endtask

   task automatic test_decode_miss();
      int n, c;
      psel_seen = 1'b0;
      araddr = 32'h0001_0000; arvalid = 1'b1;
      wait_sig(1, n);
      wait_sig(3, c);
      arvalid = 1'b0;
      tests++;
      if (n < 0 || c !== n + 1 || rresp !== 2'b11 || rdata !== 32'h0) begin
         fails++; $display("FAIL miss_rd: got cycle %0d rresp %b rdata %h expected cycle %0d rresp 11 rdata 0", c, rresp, rdata, n + 1);
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      awaddr = 32'h0000_8000; wdata = 32'h5555_5555; wstrb = 4'h3;
      awvalid = 1'b1; wvalid = 1'b1;
      wait_sig(0, n);
      wait_sig(2, c);
      awvalid = 1'b0; wvalid = 1'b0;
      tests++;
      if (n < 0 || c !== n + 1 || bresp !== 2'b11) begin
         fails++; $display("FAIL miss_wr: got cycle %0d bresp %b expected cycle %0d bresp 11", c, bresp, n + 1);
      end
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      tests++;
      if (psel_seen !== 1'b0) begin
         fails++; $display("FAIL miss_psel: got psel_seen %b expected 0", psel_seen);
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2, m, c;
      wait_cfg[1] = 0; wait_cfg[2] = 0;
      bready = 1'b1;
      awaddr = 32'h0000_1000; wdata = 32'h1111_1111; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      wait_sig(0, n1);
      @(negedge aclk);
      awaddr = 32'h0000_2004; wdata = 32'h2222_2222;
      wait_sig(2, m);
      tests++;
      if (n1 < 0 || m !== n1 + 3) begin
         fails++; $display("FAIL b2b_first: got cycle %0d expected %0d", m, n1 + 3);
      end
      wait_sig(0, n2);
      tests++;
      if (!(n2 > m)) begin
         fails++; $display("FAIL b2b_gap: got accept cycle %0d expected later than %0d", n2, m);
      end
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      tests++;
      if ({psel, paddr, pwdata} !== {4'b0100, 12'h004, 32'h2222_2222}) begin
         fails++; $display("FAIL b2b_second: got psel %b paddr %h pwdata %h expected 0100 004 22222222", psel, paddr, pwdata);
      end
      wait_sig(2, c);
      tests++;
      if (c !== n2 + 3 || bresp !== 2'b00) begin
         fails++; $display("FAIL b2b_resp: got cycle %0d bresp %b expected %0d 00", c, bresp, n2 + 3);
      end
      @(negedge aclk);
      bready = 1'b0;
   endtask

   task automatic test_arbitration();
      int c;
      logic exp_w;
      areset_n = 1'b0;
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      @(negedge aclk);
      err_cfg[0] = 1'b1; wait_cfg[0] = 0; wait_cfg[2] = 0; rdata_cfg[2] = 32'hA5A5_0002;
      bready = 1'b1; rready = 1'b1;
      for (int occ = 0; occ < 3; occ++) begin
         exp_w = (occ != 1);
         awaddr = 32'h0000_0010; wdata = 32'h0BAD_0000 + occ; wstrb = 4'hF;
         araddr = 32'h0000_2000;
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         wait_sig(4, c);
         tests++;
         if (c < 0 || {awready, arready} !== (exp_w ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL arb_grant%0d: got aw/ar %b%b expected %s", occ, awready, arready, exp_w ? "10" : "01");
         end
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         wait_sig(5, c);
         tests++;
         if (exp_w ? (bvalid !== 1'b1 || bresp !== 2'b10)
                   : (rvalid !== 1'b1 || rdata !== 32'hA5A5_0002 || rresp !== 2'b00)) begin
            fails++; $display("FAIL arb_resp%0d: got bvalid %b bresp %b rvalid %b rdata %h expected %s",
                              occ, bvalid, bresp, rvalid, rdata, exp_w ? "bresp 10" : "rdata a5a50002 rresp 00");
         end
         repeat (2) @(negedge aclk);
      end
      err_cfg[0] = 1'b0;
      bready = 1'b0; rready = 1'b0;
   endtask

   task automatic test_timeout();
      int n, c;
      araddr = 32'h0000_2000; arvalid = 1'b1;
`ifdef APB_TIMEOUT_EN
      wait_cfg[2] = 100;
`else
      wait_cfg[2] = 8; rdata_cfg[2] = 32'hCAFE_F00D;
`endif
      wait_sig(1, n);
      @(negedge aclk);
      arvalid = 1'b0;
      @(negedge aclk);
      tests++;
      if (penable !== 1'b1) begin
         fails++; $display("FAIL tmo_access: got penable %b expected 1", penable);
      end
      wait_sig(3, c);
`ifdef APB_TIMEOUT_EN
      tests++;
      if (n < 0 || c !== n + 6 || rresp !== 2'b10 || rdata !== 32'h0 || psel !== 4'b0000) begin
         fails++; $display("FAIL tmo_resp: got cycle %0d rresp %b rdata %h psel %b expected %0d 10 0 0000", c, rresp, rdata, psel, n + 6);
      end
`else
      tests++;
      if (n < 0 || c !== n + 11 || rresp !== 2'b00 || rdata !== 32'hCAFE_F00D) begin
         fails++; $display("FAIL notmo_resp: got cycle %0d rresp %b rdata %h expected %0d 00 cafef00d", c, rresp, rdata, n + 11);
      end
`endif
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      wait_cfg[2] = 0;
   endtask

   task automatic test_reset_mid();
      int n;
      logic stray;
      wait_cfg[3] = 10;
      araddr = 32'h0000_3000; arvalid = 1'b1;
      wait_sig(1, n);
      @(negedge aclk);
      arvalid = 1'b0;
      @(negedge aclk);
      tests++;
      if (n < 0 || {psel, penable} !== {4'b1000, 1'b1}) begin
         fails++; $display("FAIL rstmid_access: got psel %b en %b expected 1000 1", psel, penable);
      end
      areset_n = 1'b0;
      #1;
      tests++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
           psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
         fails++; $display("FAIL rstmid_outputs: got psel %b en %b rvalid %b paddr %h expected all 0", psel, penable, rvalid, paddr);
      end
      @(negedge aclk);
      areset_n = 1'b1;
      rready = 1'b1; bready = 1'b1;
      stray = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge aclk);
         if (rvalid || bvalid || (|psel)) stray = 1'b1;
      end
      rready = 1'b0; bready = 1'b0;
      tests++;
      if (stray !== 1'b0) begin
         fails++; $display("FAIL rstmid_dropped: got stray activity %b expected 0", stray);
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      areset_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      err_cfg = '0; psel_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_cfg[i]  = 0;
         rdata_cfg[i] = 32'h1000_0000 * (i + 1);
      end
      test_reset();
      test_write();
      test_read_wait();
      test_decode_miss();
      test_back_to_back();
      test_arbitration();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_apb_bridge_mc.md
AXI_APB_BRIDGE_MC -- requirements
Module: axi_apb_bridge_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: AXI/APB data width, a multiple of 8.
REQ-002 The block SHALL have parameter NUM_SLAVES, default 4: APB slave count, 1..16.
REQ-003 The block SHALL have parameter WIN_BITS, default 12: per-slave address window is 2^WIN_BITS bytes.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 255: ACCESS-cycle limit when timeout is compiled in.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port awaddr, input, 32 bits: AXI write address.
REQ-008 The block SHALL have port awvalid, input, 1 bit.
REQ-009 The block SHALL have port awready, output, 1 bit.
REQ-010 The block SHALL have port wdata, input, DATA_W bits.
REQ-011 The block SHALL have port wstrb, input, DATA_W/8 bits.
REQ-012 The block SHALL have port wvalid, input, 1 bit.
REQ-013 The block SHALL have port wready, output, 1 bit.
REQ-014 The block SHALL have port bresp, output, 2 bits.
REQ-015 The block SHALL have port bvalid, output, 1 bit.
REQ-016 The block SHALL have port bready, input, 1 bit.
REQ-017 The block SHALL have port araddr, input, 32 bits: AXI read address.
REQ-018 The block SHALL have port arvalid, input, 1 bit.
REQ-019 The block SHALL have port arready, output, 1 bit.
REQ-020 The block SHALL have port rdata, output, DATA_W bits.
REQ-021 The block SHALL have port rresp, output, 2 bits.
REQ-022 The block SHALL have port rvalid, output, 1 bit.
REQ-023 The block SHALL have port rready, input, 1 bit.
REQ-024 The block SHALL have port paddr, output, WIN_BITS bits: APB offset within the selected window.
REQ-025 The block SHALL have port psel, output, NUM_SLAVES bits: one-hot APB select.
REQ-026 The block SHALL have ports penable and pwrite, each output, 1 bit.
REQ-027 The block SHALL have ports pwdata (DATA_W bits) and pstrb (DATA_W/8 bits), both outputs.
REQ-028 The block SHALL have port prdata, input, NUM_SLAVES*DATA_W bits; slave i drives slice i.
REQ-029 The block SHALL have ports pready and pslverr, each input, NUM_SLAVES bits.

Function
REQ-030 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and SHALL process one transaction at a time.
REQ-031 Write acceptance in IDLE SHALL require awvalid=wvalid=1, and awready and wready SHALL then pulse together for 1 cycle.
REQ-032 Read acceptance in IDLE SHALL pulse arready for 1 cycle.
REQ-033 When a write and a read are both pending in IDLE, grant SHALL alternate between them, with write first after reset.
REQ-034 Decode SHALL be index = addr[WIN_BITS +: clog2(NUM_SLAVES)]; address bits above the index field SHALL be zero.
REQ-035 A decode miss (index >= NUM_SLAVES or a nonzero upper bit) SHALL skip APB, go directly to RESP with resp=2'b11 and rdata=0, and leave psel at 0.
REQ-036 In SETUP, psel[index] SHALL be 1 and penable 0 for exactly 1 cycle; in ACCESS, penable SHALL be 1 until pready[index]=1.
REQ-037 paddr, pwrite, pwdata and pstrb SHALL stay stable through SETUP and ACCESS, and pstrb SHALL be 0 for reads.
REQ-038 On completion, resp SHALL be 2'b10 if pslverr[index]=1, else 2'b00; rdata SHALL capture prdata slice[index].
REQ-039 In the completion cycle, psel and penable SHALL drop to 0, and the FSM SHALL enter RESP.
REQ-040 In RESP, bvalid/rvalid SHALL be held, with bresp/rresp and rdata stable, until bready/rready; then the FSM SHALL return to IDLE.
REQ-041 Latency with a zero-wait slave SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2, valid at N+3.
REQ-042 A new transaction SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-043 While areset_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the grant SHALL be write-first; assertion mid-transaction SHALL drop the transaction immediately without a response.

Configuration
REQ-044 With macro APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYC cycles pass without pready, the block SHALL drop psel/penable, respond 2'b10 with rdata=0, and enter RESP.
REQ-045 With APB_TIMEOUT_EN undefined, there SHALL be no counter, and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-046 Write 0x0000_1004 with data 0xDEADBEEF and wstrb 0xF, slave 1 zero-wait -> psel=4'b0010, paddr=0x004, pwdata=0xDEADBEEF, bvalid at cycle N+3 with bresp=00.
REQ-047 Read 0x0000_3008, slave 3 with 2 wait states and prdata=0x12345678 -> rvalid at N+5, rdata=0x12345678, rresp=00, pstrb=0.
REQ-048 Read 0x0001_0000 -> psel never asserted, rvalid at N+1, rresp=11, rdata=0.
REQ-049 Write and read both pending on 3 successive occasions -> grant order W, R, W; slave 0 with pslverr=1 -> bresp=10.
REQ-050 With APB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held 0 -> response at ACCESS+4 with resp=10; areset_n low in ACCESS -> all outputs 0 in the same cycle.
